// File: rtl/sd_fifo_pkg.sv
// sd_fifo_pkg: shared constants and types
// for the SD data byte FIFO.
package sd_fifo_pkg;

  localparam int FIFO_AW      = 11;
  localparam int SECTOR_BYTES = 512;

  typedef logic [7:0] byte_t;

endpackage

// File: rtl/sd_fifo_obuf.sv
// sd_fifo_obuf: 2-entry prefetch / skid buffer
// that turns registered RAM reads into an FWFT head.
module sd_fifo_obuf
  import sd_fifo_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic [1:0] ocnt,
  output logic [1:0] ocnt_nxt
);

  byte_t      buf0;
  byte_t      buf1;
  logic [1:0] slot;

  // slot left free once a pop has shifted the buffer
  assign slot = ocnt - {1'b0, pop};
  assign head = buf0;

  // next occupancy: loads in, pops out, clear wins
  always_comb begin
    ocnt_nxt = ocnt;
    if (clr) begin
      ocnt_nxt = '0;
    end else begin
      ocnt_nxt = ocnt + {1'b0, load} - {1'b0, pop};
    end
  end

  // shift on pop, then drop a returned byte into the free slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ocnt <= '0;
      buf0 <= '0;
      buf1 <= '0;
    end else begin
      ocnt <= ocnt_nxt;
      if (pop) begin
        buf0 <= buf1;
      end
      if (load) begin
        if (slot == 2'd0) begin
          buf0 <= load_data;
        end else begin
          buf1 <= load_data;
        end
      end
    end
  end

endmodule

// File: rtl/sd_fifo_ctrl.sv
// sd_fifo_ctrl: byte FIFO controller over a
// 2048x8 dual-port RAM with an FWFT output.
module sd_fifo_ctrl
  import sd_fifo_pkg::*;
#(
  parameter int AW       = FIFO_AW,
  parameter int AFULL_TH = 1984,
  parameter int SECTOR   = SECTOR_BYTES
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [7:0]    s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [7:0]    m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [AW:0]   level,
  output logic          afull,
  output logic          sect_avail,
  output logic          empty,
  output logic [AW-1:0] mem_adr_a,
  output logic [7:0]    mem_d_a,
  output logic          mem_we_a,
  output logic [AW-1:0] mem_adr_b,
  input  logic [7:0]    mem_q_b,
  output logic          mem_we_b,
  output logic [7:0]    mem_d_b
);

  localparam int          DEPTH   = 2 ** AW;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0] AFULL_C = (AW + 1)'(AFULL_TH);
  localparam logic [AW:0] SECT_C  = (AW + 1)'(SECTOR);

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   ram_cnt;
  logic [AW:0]   ram_cnt_nxt;
  logic [AW:0]   level_nxt;
  logic          infl;
  logic [1:0]    ocnt;
  logic [1:0]    ocnt_nxt;
  logic [2:0]    occ;
  logic          push;
  logic          pop;
  logic          fetch;
  logic          load;

  assign s_ready = rst_n & (ram_cnt != DEPTH_C) & ~flush;
  assign push    = s_valid & s_ready;
  assign m_valid = (ocnt != 2'd0);
  assign pop     = m_valid & m_ready;

  // fetch only while the buffer can absorb the return
  assign occ   = {1'b0, ocnt} + {2'b00, infl};
  assign fetch = ~flush & (ram_cnt != '0)
               & (occ < 3'd2 + {2'b00, pop});
  assign load  = infl & ~flush;

  assign mem_adr_a = wptr;
  assign mem_d_a   = s_data;
  assign mem_we_a  = push;
  assign mem_adr_b = rptr;
  assign mem_we_b  = 1'b0;
  assign mem_d_b   = '0;

  // words resident in RAM after this cycle
  always_comb begin
    ram_cnt_nxt = ram_cnt;
    if (flush) begin
      ram_cnt_nxt = '0;
    end else begin
      ram_cnt_nxt = ram_cnt
                  + {{AW{1'b0}}, push}
                  - {{AW{1'b0}}, fetch};
    end
  end

  assign level_nxt = ram_cnt_nxt
                   + {{AW{1'b0}}, fetch}
                   + {{(AW-1){1'b0}}, ocnt_nxt};

  // RAM pointers, resident count and in-flight read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      ram_cnt <= '0;
      infl    <= 1'b0;
    end else if (flush) begin
      wptr    <= '0;
      rptr    <= '0;
      ram_cnt <= '0;
      infl    <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (fetch) begin
        rptr <= rptr + 1'b1;
      end
      ram_cnt <= ram_cnt_nxt;
      infl    <= fetch;
    end
  end

  // level and status flags, registered from next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level      <= '0;
      empty      <= 1'b1;
      afull      <= 1'b0;
      sect_avail <= 1'b0;
    end else begin
      level      <= level_nxt;
      empty      <= (level_nxt == '0);
      afull      <= (level_nxt >= AFULL_C);
      sect_avail <= (level_nxt >= SECT_C);
    end
  end

  sd_fifo_obuf u_obuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (flush),
    .load      (load),
    .load_data (mem_q_b),
    .pop       (pop),
    .head      (m_data),
    .ocnt      (ocnt),
    .ocnt_nxt  (ocnt_nxt)
  );

endmodule

// File: tb/tb_sd_fifo_ctrl.sv
// tb_sd_fifo_ctrl: directed bench for sd_fifo_ctrl
// with a behavioural 2048x8 dual-port RAM.
module tb_sd_fifo_ctrl;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b1;
  logic        flush   = 1'b0;
  logic        s_valid = 1'b0;
  logic        m_ready = 1'b0;
  logic [7:0]  s_data  = 8'h00;
  logic [7:0]  m_data;
  logic        s_ready;
  logic        m_valid;
  logic [11:0] level;
  logic        afull;
  logic        sect_avail;
  logic        empty;
  logic [10:0] mem_adr_a;
  logic [7:0]  mem_d_a;
  logic        mem_we_a;
  logic [10:0] mem_adr_b;
  logic [7:0]  mem_q_b;
  logic        mem_we_b;
  logic [7:0]  mem_d_b;

  logic [7:0]  ram [2048];
  logic [7:0]  q [$];
  int          n_chk  = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we_a) ram[mem_adr_a] <= mem_d_a;
    mem_q_b <= ram[mem_adr_b];
  end

  sd_fifo_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .level      (level),
    .afull      (afull),
    .sect_avail (sect_avail),
    .empty      (empty),
    .mem_adr_a  (mem_adr_a),
    .mem_d_a    (mem_d_a),
    .mem_we_a   (mem_we_a),
    .mem_adr_b  (mem_adr_b),
    .mem_q_b    (mem_q_b),
    .mem_we_b   (mem_we_b),
    .mem_d_b    (mem_d_b)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // push cnt bytes with m_ready low, starting at a negedge
  task automatic push_n(input int cnt, input logic [7:0] base);
    int n;
    int cyc;
    n = 0;
    cyc = 0;
    s_valid = 1'b1;
    while (n < cnt && cyc < cnt + 100) begin
      s_data = base + 8'(n);
      if (s_ready) begin
        q.push_back(s_data);
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    s_valid = 1'b0;
    chk("push_cnt", n, cnt);
  endtask

  // pop everything in the scoreboard and compare order
  task automatic drain(input int budget);
    int bad;
    int cyc;
    logic [7:0] e;
    bad = 0;
    cyc = 0;
    m_ready = 1'b1;
    while (q.size() > 0 && cyc < budget) begin
      if (m_valid) begin
        e = q.pop_front();
        if (m_data !== e) bad++;
      end
      @(negedge clk);
      cyc++;
    end
    m_ready = 1'b0;
    chk("drain_left", q.size(), 0);
    chk("drain_order", bad, 0);
    q.delete();
  endtask

  initial begin
    logic [7:0]  v1 [3];
    logic [7:0]  pv;
    logic [10:0] pa;
    logic [10:0] pb;
    int n, cyc, lvl_bad, flag_bad;
    int bad, gaps, stalls, wa, wb;
    logic [7:0] e;

    v1[0] = 8'h11;
    v1[1] = 8'h22;
    v1[2] = 8'h33;

    // reset with a write request pending
    #1 rst_n = 1'b0;
    s_valid = 1'b1;
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_afull", afull, 0);
    chk("rst_sect", sect_avail, 0);
    chk("rst_we_a", mem_we_a, 0);
    chk("rst_adr_a", mem_adr_a, 0);
    chk("rst_adr_b", mem_adr_b, 0);
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_s_ready", s_ready, 1);
    @(negedge clk);

    // three pushes, head latency and level
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data = v1[i];
      q.push_back(v1[i]);
      @(negedge clk);
      if (i == 1) chk("lat_e2_valid", m_valid, 0);
    end
    s_valid = 1'b0;
    chk("lat_e3_valid", m_valid, 1);
    chk("lat_e3_data", m_data, 8'h11);
    chk("lat_level3", level, 3);
    repeat (3) @(negedge clk);
    drain(20);
    chk("p1_level0", level, 0);

    // fill to capacity, flags against level
    n = 0;
    cyc = 0;
    lvl_bad = 0;
    flag_bad = 0;
    s_valid = 1'b1;
    while (n < 2050 && cyc < 2200) begin
      s_data = 8'(n * 3 + 1);
      if (s_ready) begin
        q.push_back(s_data);
        n++;
      end
      @(negedge clk);
      cyc++;
      if (level !== 12'(n)) lvl_bad++;
      if (sect_avail !== (n >= 512)) flag_bad++;
      if (afull !== (n >= 1984)) flag_bad++;
      if (n == 511) chk("sect_511", sect_avail, 0);
      if (n == 512) chk("sect_512", sect_avail, 1);
      if (n == 1983) chk("afull_1983", afull, 0);
      if (n == 1984) chk("afull_1984", afull, 1);
    end
    chk("fill_cnt", n, 2050);
    chk("fill_level_trk", lvl_bad, 0);
    chk("fill_flag_trk", flag_bad, 0);
    chk("full_s_ready", s_ready, 0);
    chk("full_level", level, 2050);
    chk("full_afull", afull, 1);
    chk("full_sect", sect_avail, 1);
    chk("full_head", m_data, q[0]);

    // sustained push and pop from full
    m_ready = 1'b1;
    pv = 8'h00;
    bad = 0;
    gaps = 0;
    stalls = 0;
    lvl_bad = 0;
    wa = 0;
    wb = 0;
    pa = mem_adr_a;
    pb = mem_adr_b;
    for (int c = 0; c < 5000; c++) begin
      s_data = pv;
      if (s_ready) begin
        q.push_back(pv);
        pv = pv + 8'd1;
      end else if (c != 0) begin
        stalls++;
      end
      if (m_valid) begin
        e = q.pop_front();
        if (m_data !== e) bad++;
      end else begin
        gaps++;
      end
      if (c != 0 && level !== 12'd2049) lvl_bad++;
      @(negedge clk);
      if (pa == 11'd2047 && mem_adr_a == 11'd0) wa++;
      if (pb == 11'd2047 && mem_adr_b == 11'd0) wb++;
      pa = mem_adr_a;
      pb = mem_adr_b;
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    chk("strm_order", bad, 0);
    chk("strm_gaps", gaps, 0);
    chk("strm_stalls", stalls, 0);
    chk("strm_level", lvl_bad, 0);
    chk("strm_wrap_a", wa, 2);
    chk("strm_wrap_b", wb, 2);
    chk("strm_q", q.size(), 2049);
    drain(3000);
    chk("strm_empty", empty, 1);
    chk("strm_level0", level, 0);

    // single byte popped as soon as it appears
    s_valid = 1'b1;
    s_data = 8'h5A;
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    chk("one_e2_valid", m_valid, 0);
    m_ready = 1'b1;
    @(negedge clk);
    chk("one_valid", m_valid, 1);
    chk("one_data", m_data, 8'h5A);
    chk("one_level", level, 1);
    @(negedge clk);
    m_ready = 1'b0;
    chk("one_pop_valid", m_valid, 0);
    chk("one_pop_empty", empty, 1);
    chk("one_pop_level", level, 0);

    // flush during a RAM return with a push presented
    s_valid = 1'b1;
    s_data = 8'h77;
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    s_valid = 1'b1;
    s_data = 8'h99;
    #1 chk("fl_s_ready", s_ready, 0);
    chk("fl_we_a", mem_we_a, 0);
    @(negedge clk);
    flush = 1'b0;
    chk("fl_level", level, 0);
    chk("fl_valid", m_valid, 0);
    chk("fl_empty", empty, 1);
    s_data = 8'hA5;
    #1 chk("fl_adr_a", mem_adr_a, 0);
    chk("fl_push_we", mem_we_a, 1);
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    chk("fl_a5_early", m_valid, 0);
    @(negedge clk);
    chk("fl_a5_valid", m_valid, 1);
    chk("fl_a5_data", m_data, 8'hA5);
    chk("fl_a5_level", level, 1);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("fl_pop_level", level, 0);

    // asynchronous reset mid-stream at level 700
    push_n(700, 8'h40);
    chk("mr_level", level, 700);
    chk("mr_sect", sect_avail, 1);
    s_valid = 1'b1;
    rst_n = 1'b0;
    #1 chk("mr_valid", m_valid, 0);
    chk("mr_level0", level, 0);
    chk("mr_empty", empty, 1);
    chk("mr_afull", afull, 0);
    chk("mr_sect0", sect_avail, 0);
    chk("mr_we_a", mem_we_a, 0);
    chk("mr_adr_a", mem_adr_a, 0);
    chk("mr_adr_b", mem_adr_b, 0);
    q.delete();
    @(negedge clk);
    s_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    s_valid = 1'b1;
    s_data = 8'hC3;
    #1 chk("mr_push_adr", mem_adr_a, 0);
    chk("mr_push_we", mem_we_a, 1);
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    chk("mr_c3_early", m_valid, 0);
    @(negedge clk);
    chk("mr_c3_valid", m_valid, 1);
    chk("mr_c3_data", m_data, 8'hC3);
    chk("mr_c3_level", level, 1);
    chk("mr_wptr1", mem_adr_a, 1);
    chk("mr_rptr1", mem_adr_b, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
